fetch_ctrl: RTL

Sequencer for the instruction-fetch front end of the RISC pipeline. It owns the program counter and drives the IF stage fetch address. It generates the write-enable and flush controls for the PC register and the IF/DE pipeline register. It arbitrates between sequential fetch, branch redirect, decode stall and halt, with a fixed priority.

---
 rtl/fetch_ctrl.sv | 100 ++++++++++
 1 files changed

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer owning the PC; FETCH_PERF_CNT_EN adds stall/flush counters
module fetch_ctrl #(
    parameter int          ADDR_WIDTH = 32,
    parameter int unsigned PC_INC     = 1,
    parameter int unsigned RESET_PC   = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] in_Addr,
    input  logic                  isBranchTaken,
    input  logic                  stall_req,
    input  logic                  halt_req,
    input  logic                  resume,
    output logic [ADDR_WIDTH-1:0] pc_out,
    output logic                  pc_write_en,
    output logic                  if_de_write_en,
    output logic                  if_de_flush,
    output logic                  fetch_valid,
`ifdef FETCH_PERF_CNT_EN
    output logic [1:0]            state_out,
    output logic [15:0]           stall_cnt,
    output logic [15:0]           flush_cnt
`else
    output logic [1:0]            state_out
`endif
);
    typedef enum logic [1:0] {RUN = 2'd0, STALL = 2'd1, FLUSH = 2'd2, HALT = 2'd3} state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic [3:0]            r_ctl;
    state_t                w_next_state;
    logic [ADDR_WIDTH-1:0] w_next_pc;
    logic [ADDR_WIDTH-1:0] w_pc_inc;
    logic [3:0]            w_next_ctl;

    assign w_pc_inc = r_pc + ADDR_WIDTH'(PC_INC);
    assign pc_out = r_pc;
    assign state_out = r_state;
    assign {pc_write_en, if_de_write_en, if_de_flush, fetch_valid} = r_ctl;

    // Fixed-priority arbitration: branch > halt > stall > sequential fetch
    always_comb begin
        w_next_state = r_state;
        w_next_pc = r_pc;
        case (r_state)
            RUN, STALL: begin
                if (isBranchTaken) begin
                    w_next_state = FLUSH;
                    w_next_pc = in_Addr;
                end else if (halt_req) begin
                    w_next_state = HALT;
                end else if (stall_req) begin
                    w_next_state = STALL;
                end else begin
                    w_next_state = RUN;
                    w_next_pc = (r_state == RUN) ? w_pc_inc : r_pc;
                end
            end
            FLUSH: begin
                w_next_state = isBranchTaken ? FLUSH : RUN;
                w_next_pc = isBranchTaken ? in_Addr : w_pc_inc;
            end
            default: w_next_state = resume ? RUN : HALT;
        endcase
    end

    // Moore control decode of the upcoming state, so outputs are registered alongside it
    always_comb begin
        w_next_ctl = (w_next_state == RUN)   ? 4'b1101 :
                     (w_next_state == STALL) ? 4'b0001 :
                     (w_next_state == FLUSH) ? 4'b1110 : 4'b0000;
    end

    // State, PC and control registers; reset lands in RUN at RESET_PC
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= RUN;
            r_pc <= ADDR_WIDTH'(RESET_PC);
            r_ctl <= 4'b1101;
        end else begin
            r_state <= w_next_state;
            r_pc <= w_next_pc;
            r_ctl <= w_next_ctl;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    // Saturating counters: cycles spent stalled, entries into FLUSH
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (r_state == STALL && ~&stall_cnt) stall_cnt <= stall_cnt + 16'd1;
            if (w_next_state == FLUSH && ~&flush_cnt) flush_cnt <= flush_cnt + 16'd1;
        end
    end
`endif
endmodule
